echo_delay_unit: RTL and testbench

- Audio post-processing stage between the music player's 16-bit sample output and the AC97 codec's playback input.
- Once per codec frame it mixes the current dry sample with an attenuated copy of the sample from DELAY_SAMPLES frames earlier, held in a circular delay-line RAM.
- The result is presented to the codec before the next frame request.
- Bypass is selected by echo_switch.

---
 rtl/echo_delay_unit.sv | 121 ++++++++++++
 tb/tb_echo_delay_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_unit.sv
// Echo stage between player and codec: mixes each dry sample with an attenuated copy from DELAY_SAMPLES frames back.
// Optional macro ECHO_FEEDBACK_EN stores the mix in the delay line for recirculating repeats; otherwise it stores the dry sample.
module echo_delay_unit #(
   parameter int DELAY_SAMPLES = 4096,
   parameter int ADDR_WIDTH    = 12,
   parameter int DECAY_SHIFT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_frame,
   input  logic [15:0] sample_in,
   input  logic        echo_switch,
   output logic [15:0] sample_out,
   output logic        out_valid,
   output logic        overrun
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_MIX, S_WRITE} state_t;

   localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DELAY_SAMPLES);

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]     r_fill;
   logic [15:0]             r_held_in;
   logic                    r_held_echo;
   logic [15:0]             r_rd_data;
   logic signed [15:0]      r_delayed;
   logic [15:0]             r_mix;
   logic [15:0]             r_sample_out;
   logic                    r_out_valid;
   logic                    r_overrun;
   logic [15:0]             r_mem [DELAY_SAMPLES];

   logic signed [15:0]      w_decayed;
   logic [16:0]             w_sum;
   logic [15:0]             w_sat;
   logic [15:0]             w_wr_data;

   assign w_decayed = $signed(r_rd_data) >>> DECAY_SHIFT;

   // 17-bit sign-extended sum; the two top bits disagree only on overflow.
   assign w_sum = {r_held_in[15], r_held_in} + {r_delayed[15], r_delayed};

   always_comb begin
      w_sat = w_sum[15:0];
      if (w_sum[16:15] == 2'b01) begin
         w_sat = 16'h7FFF;
      end else if (w_sum[16:15] == 2'b10) begin
         w_sat = 16'h8000;
      end
   end

`ifdef ECHO_FEEDBACK_EN
   assign w_wr_data = r_held_echo ? r_mix : r_held_in;
`else
   assign w_wr_data = r_held_in;
`endif

   // NOTE: the delay-line RAM has no reset; unfilled entries are masked by r_fill instead.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && new_frame) begin
         r_rd_data <= r_mem[r_wr_ptr];
      end
      if (r_state == S_WRITE) begin
         r_mem[r_wr_ptr] <= w_wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_fill       <= '0;
         r_held_in    <= '0;
         r_held_echo  <= 1'b0;
         r_delayed    <= '0;
         r_mix        <= '0;
         r_sample_out <= '0;
         r_out_valid  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (new_frame && r_state != S_IDLE) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (new_frame) begin
                  r_held_in   <= sample_in;
                  r_held_echo <= echo_switch;
                  r_state     <= S_READ;
               end
            end
            S_READ: begin
               r_delayed <= (r_fill < FILL_MAX) ? 16'sd0 : w_decayed;
               r_state   <= S_MIX;
            end
            S_MIX: begin
               r_mix   <= w_sat;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_sample_out <= r_held_echo ? r_mix : r_held_in;
               r_out_valid  <= 1'b1;
               r_wr_ptr     <= r_wr_ptr + 1'b1;
               if (r_fill < FILL_MAX) begin
                  r_fill <= r_fill + 1'b1;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sample_out = r_sample_out;
   assign out_valid  = r_out_valid;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_echo_delay_unit.sv
// Self-checking bench for echo_delay_unit: two instances (decay shift 1 and 0) share stimulus
// and are compared against a frame-history reference model.
module tb_echo_delay_unit;

   localparam int D = 4;
`ifdef ECHO_FEEDBACK_EN
   localparam bit FEEDBACK = 1'b1;
`else
   localparam bit FEEDBACK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        new_frame = 1'b0;
   logic [15:0] sample_in = '0;
   logic        echo_switch = 1'b0;
   logic [15:0] out_a, out_b;
   logic        valid_a, valid_b;
   logic        ovr_a, ovr_b;

   int checks = 0;
   int failures = 0;

   // Frame history of values written to each delay line, indexed by accepted-frame number.
   int hist_a [0:255];
   int hist_b [0:255];
   int n_frames = 0;
   int exp_a = 0;
   int exp_b = 0;
   bit exp_ovr = 1'b0;

   always #5 clk = ~clk;

   echo_delay_unit #(.DELAY_SAMPLES(D), .ADDR_WIDTH(2), .DECAY_SHIFT(1)) u_dut_a (
      .clk(clk), .reset(reset), .new_frame(new_frame), .sample_in(sample_in),
      .echo_switch(echo_switch), .sample_out(out_a), .out_valid(valid_a), .overrun(ovr_a)
   );

   echo_delay_unit #(.DELAY_SAMPLES(D), .ADDR_WIDTH(2), .DECAY_SHIFT(0)) u_dut_b (
      .clk(clk), .reset(reset), .new_frame(new_frame), .sample_in(sample_in),
      .echo_switch(echo_switch), .sample_out(out_b), .out_valid(valid_b), .overrun(ovr_b)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Output of one accepted frame: dry + (sample written D frames ago >>> shift), saturated.
   task automatic model_frame(input int s, input bit e);
      int da, db, ma, mb;
      da = (n_frames >= D) ? (hist_a[n_frames-D] >>> 1) : 0;
      db = (n_frames >= D) ? hist_b[n_frames-D] : 0;
      ma = sat16(s + da);
      mb = sat16(s + db);
      exp_a = e ? ma : s;
      exp_b = e ? mb : s;
      hist_a[n_frames] = (FEEDBACK && e) ? ma : s;
      hist_b[n_frames] = (FEEDBACK && e) ? mb : s;
      n_frames++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_frames = 0;
      exp_ovr = 1'b0;
      exp_a = 0;
      exp_b = 0;
   endtask

   // One accepted frame; optionally a second pulse lands two cycles later while busy.
   task automatic do_frame(input int s, input bit e, input bit glitch, input string tag);
      int prev_a, prev_b;
      prev_a = exp_a;
      prev_b = exp_b;
      @(negedge clk);
      new_frame = 1'b1;
      sample_in = 16'(s);
      echo_switch = e;
      @(posedge clk);
      #1 new_frame = 1'b0;
      echo_switch = ~e;
      sample_in = 16'($urandom);
      model_frame(s, e);
      check({tag, "_valid_e0"}, {31'd0, valid_a}, 0);
      for (int k = 1; k <= 2; k++) begin
         if (glitch && k == 2) begin
            @(negedge clk);
            new_frame = 1'b1;
            exp_ovr = 1'b1;
         end
         @(posedge clk);
         #1 new_frame = 1'b0;
         check({tag, "_valid_early"}, {31'd0, valid_a}, 0);
         check({tag, "_hold_a"}, $signed(out_a), prev_a);
      end
      @(posedge clk);
      #1;
      check({tag, "_valid_a"}, {31'd0, valid_a}, 1);
      check({tag, "_valid_b"}, {31'd0, valid_b}, 1);
      check({tag, "_out_a"}, $signed(out_a), exp_a);
      check({tag, "_out_b"}, $signed(out_b), exp_b);
      check({tag, "_overrun"}, {31'd0, ovr_a}, {31'd0, exp_ovr});
      check({tag, "_overrun_b"}, {31'd0, ovr_b}, {31'd0, exp_ovr});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int impulse [9];
      impulse = '{1000, 0, 0, 0, 0, 0, 0, 0, 0};

      do_reset();
      #1;
      check("reset_out", $signed(out_a), 0);
      check("reset_valid", {31'd0, valid_a}, 0);
      check("reset_overrun", {31'd0, ovr_a}, 0);

      // Impulse response: 1000, 0,0,0, 500, 0,0,0, 250 (feedback) or 0.
      for (int i = 0; i < 9; i++) do_frame(impulse[i], 1'b1, 1'b0, $sformatf("impulse%0d", i));
      check("impulse_tail_a", $signed(out_a), FEEDBACK ? 250 : 0);

      // Bypass passes the dry sample through.
      do_frame(1000, 1'b0, 1'b0, "bypass0");
      do_frame(2000, 1'b0, 1'b0, "bypass1");
      do_frame(3000, 1'b0, 1'b0, "bypass2");
      check("bypass_last", $signed(out_a), 3000);

      // Positive and negative saturation.
      do_reset();
      do_frame(30000, 1'b1, 1'b0, "satp0");
      for (int i = 1; i < 4; i++) do_frame(0, 1'b1, 1'b0, $sformatf("satp%0d", i));
      do_frame(30000, 1'b1, 1'b0, "satp4");
      check("sat_pos_b", $signed(out_b), 32767);
      do_reset();
      do_frame(-30000, 1'b1, 1'b0, "satn0");
      for (int i = 1; i < 4; i++) do_frame(0, 1'b1, 1'b0, $sformatf("satn%0d", i));
      do_frame(-30000, 1'b1, 1'b0, "satn4");
      check("sat_neg_b", $signed(out_b), -32768);

      // Overrun: the glitch pulse is dropped, flag sticks, echo alignment stays intact.
      do_frame(1200, 1'b1, 1'b1, "ovr0");
      for (int i = 1; i < 6; i++) do_frame(i * 100, 1'b1, 1'b0, $sformatf("ovr%0d", i));

      // Random frames with pointer wrap and random echo enable.
      do_reset();
      for (int i = 0; i < 9; i++)
         do_frame($signed(16'($urandom)), 1'b1, 1'b0, $sformatf("wrap%0d", i));
      for (int i = 0; i < 8; i++)
         do_frame($signed(16'($urandom)), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", i));
      do_frame(1, 1'b1, 1'b1, "ovr_again");

      // Reset while in READ aborts the frame; afterwards the line is treated as empty.
      @(negedge clk);
      new_frame = 1'b1;
      sample_in = 16'd7777;
      echo_switch = 1'b1;
      @(posedge clk);
      #1 new_frame = 1'b0;
      reset = 1'b1;
      #1;
      check("midreset_out", $signed(out_a), 0);
      check("midreset_valid", {31'd0, valid_a}, 0);
      check("midreset_overrun", {31'd0, ovr_a}, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_frames = 0;
      exp_ovr = 1'b0;
      exp_a = 0;
      exp_b = 0;
      do_frame(1234, 1'b1, 1'b0, "post0");
      for (int i = 1; i < 4; i++) do_frame(0, 1'b1, 1'b0, $sformatf("post%0d", i));
      do_frame(0, 1'b1, 1'b0, "post4");
      check("post_echo_a", $signed(out_a), 617);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
